// File: rtl/cache_pkg.sv
// Shared definitions for the cache refill buffer.
//
// Holds the bus/line geometry, the refill FSM state type and two small
// helpers: line-address alignment and byte-mask expansion. Every rtl/
// file and the bench import this package.
package cache_pkg;

    localparam int DATA_WIDTH      = 32;
    localparam int CACHE_LINE_SIZE = 512;
    localparam int ADDR_WIDTH      = 32;

    localparam int MASK_W      = DATA_WIDTH / 8;
    localparam int BEATS       = CACHE_LINE_SIZE / DATA_WIDTH;
    localparam int OFF_W       = $clog2(BEATS);
    localparam int LINE_BYTE_W = $clog2(CACHE_LINE_SIZE / 8);

    // Burst length field uses the "beats minus one" encoding.
    localparam logic [7:0] BURST_LEN = 8'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RECV  = 2'd2,
        WRITE = 2'd3
    } state_t;

    // Clear the byte-within-line bits so the address points at the first
    // byte of the line.
    function automatic logic [ADDR_WIDTH-1:0] align_line(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] keep;
        keep = '1;
        keep = keep << LINE_BYTE_W;
        return addr & keep;
    endfunction

    // Expand one enable bit per byte into a full-width bit mask.
    function automatic logic [DATA_WIDTH-1:0] expand_mask(input logic [MASK_W-1:0] mask);
        logic [DATA_WIDTH-1:0] ext;
        ext = '0;
        for (int b = 0; b < MASK_W; b++) begin
            ext[8*b +: 8] = {8{mask[b]}};
        end
        return ext;
    endfunction

endpackage

// File: rtl/cache_refill_buffer_if.sv
// Signal bundle between the cache refill buffer and its neighbours.
//
// Groups three channels:
//   miss_*     : miss request from the miss-detect logic
//   rd_req_* /
//   rd_resp_*  : burst read request and read-beat response of the memory bus
//   word_* /
//   line_* /
//   err        : critical-word forward, assembled line to the data array,
//                sticky burst protocol error
//
// Modports:
//   slave  : the refill buffer's view
//   master : the environment's view (miss source, memory, data array)
interface cache_refill_buffer_if;
    import cache_pkg::*;

    // miss request
    logic                       miss_valid;
    logic                       miss_ready;
    logic [ADDR_WIDTH-1:0]      miss_addr;
    logic [OFF_W-1:0]           miss_offset;
    logic                       miss_we;
    logic [DATA_WIDTH-1:0]      miss_wdata;
    logic [MASK_W-1:0]          miss_wmask;

    // burst read request
    logic                       rd_req_valid;
    logic                       rd_req_ready;
    logic [ADDR_WIDTH-1:0]      rd_req_addr;
    logic [7:0]                 rd_req_len;

    // read beats
    logic                       rd_resp_valid;
    logic                       rd_resp_ready;
    logic [DATA_WIDTH-1:0]      rd_resp_data;
    logic                       rd_resp_last;

    // critical word / line write / status
    logic                       word_valid;
    logic [DATA_WIDTH-1:0]      word_data;
    logic                       line_valid;
    logic                       line_ready;
    logic [CACHE_LINE_SIZE-1:0] line_data;
    logic [ADDR_WIDTH-1:0]      line_addr;
    logic                       err;

    modport slave (
        input  miss_valid, miss_addr, miss_offset, miss_we, miss_wdata, miss_wmask,
        output miss_ready,
        output rd_req_valid, rd_req_addr, rd_req_len,
        input  rd_req_ready,
        input  rd_resp_valid, rd_resp_data, rd_resp_last,
        output rd_resp_ready,
        output word_valid, word_data,
        output line_valid, line_data, line_addr,
        input  line_ready,
        output err
    );

    modport master (
        output miss_valid, miss_addr, miss_offset, miss_we, miss_wdata, miss_wmask,
        input  miss_ready,
        input  rd_req_valid, rd_req_addr, rd_req_len,
        output rd_req_ready,
        output rd_resp_valid, rd_resp_data, rd_resp_last,
        input  rd_resp_ready,
        input  word_valid, word_data,
        input  line_valid, line_data, line_addr,
        output line_ready,
        input  err
    );

endinterface

// File: rtl/cache_refill_buffer_beat_merge.sv
// Byte-mask merge of a store word into a memory word.
//
// Ports:
//   i_old    : word as returned by memory
//   i_new    : pending store data
//   i_mask   : store byte enables, one bit per byte
//   i_en     : merge enable; when low the old word passes unchanged
//   o_merged : merged word
module beat_merge
    import cache_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] i_old,
    input  logic [DATA_WIDTH-1:0] i_new,
    input  logic [MASK_W-1:0]     i_mask,
    input  logic                  i_en,
    output logic [DATA_WIDTH-1:0] o_merged
);

    logic [DATA_WIDTH-1:0] w_ext_mask;

    assign w_ext_mask = i_en ? expand_mask(i_mask) : '0;
    assign o_merged   = (i_old & ~w_ext_mask) | (i_new & w_ext_mask);

endmodule

// File: rtl/cache_refill_buffer.sv
// Cache line refill buffer.
//
// Accepts one line miss, issues a single burst read for the line, collects
// BEATS sequential words into a line buffer (merging the pending store bytes
// into the requested word on a store miss), forwards the requested word early
// on a load miss and finally presents the whole line for the data-array write.
//
// Ports:
//   clk          : clock
//   reset        : synchronous, active-high reset; aborts any refill in flight
//   bus          : slave modport of cache_refill_buffer_if (miss, burst read,
//                  critical word, line write, err)
//   o_dbg_state  : current FSM state, for observation only
//
// Handshakes: every valid/ready pair transfers on a rising clk edge where both
// are high. A source holds valid and its payload stable until that edge; the
// sink may raise or lower ready freely. word_valid is a one-cycle pulse with
// no ready.
module cache_refill_buffer
    import cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    cache_refill_buffer_if.slave   bus,
    output state_t                 o_dbg_state
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                               r_state;
    logic [ADDR_WIDTH-1:0]                r_addr;
    logic [OFF_W-1:0]                     r_offset;
    logic                                 r_we;
    logic [DATA_WIDTH-1:0]                r_wdata;
    logic [MASK_W-1:0]                    r_wmask;
    logic [OFF_W-1:0]                     r_cnt;
    logic [BEATS-1:0][DATA_WIDTH-1:0]     r_line;
    logic                                 r_err;
    logic                                 r_word_valid;
    logic [DATA_WIDTH-1:0]                r_word_data;

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    state_t                w_next_state;
    logic                  w_miss_hs;
    logic                  w_req_hs;
    logic                  w_beat_hs;
    logic                  w_line_hs;
    logic                  w_hit_offset;
    logic                  w_final_slot;
    logic                  w_burst_end;
    logic                  w_burst_err;
    logic                  w_zero_merge;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_miss_hs    = (r_state == IDLE)  && bus.miss_valid;
    assign w_req_hs     = (r_state == REQ)   && bus.rd_req_ready;
    assign w_beat_hs    = (r_state == RECV)  && bus.rd_resp_valid;
    assign w_line_hs    = (r_state == WRITE) && bus.line_ready;

    assign w_hit_offset = (r_cnt == r_offset);
    assign w_final_slot = (r_cnt == OFF_W'(BEATS - 1));

    // The burst ends on the last flag or when the buffer's final slot is
    // filled, whichever comes first. Any disagreement between the two is a
    // protocol error: early last, or a missing last on the final slot.
    assign w_burst_end  = w_beat_hs && (bus.rd_resp_last || w_final_slot);
    assign w_burst_err  = w_beat_hs && (bus.rd_resp_last != w_final_slot);

    // An early last leaves the requested slot unfilled; a pending store is
    // still merged into it, onto a zero word.
    assign w_zero_merge = w_beat_hs && bus.rd_resp_last && r_we && (r_offset > r_cnt);

    beat_merge u_beat_merge (
        .i_old    (bus.rd_resp_data),
        .i_new    (r_wdata),
        .i_mask   (r_wmask),
        .i_en     (r_we && w_hit_offset),
        .o_merged (w_merged)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_miss_hs)   w_next_state = REQ;
            REQ:     if (w_req_hs)    w_next_state = RECV;
            RECV:    if (w_burst_end) w_next_state = WRITE;
            WRITE:   if (w_line_hs)   w_next_state = IDLE;
            default:                  w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.miss_ready    = 1'b0;
        bus.rd_req_valid  = 1'b0;
        bus.rd_resp_ready = 1'b0;
        bus.line_valid    = 1'b0;
        case (r_state)
            IDLE:    bus.miss_ready    = 1'b1;
            REQ:     bus.rd_req_valid  = 1'b1;
            RECV:    bus.rd_resp_ready = 1'b1;
            WRITE:   bus.line_valid    = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_offset     <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_cnt        <= '0;
            r_line       <= '0;
            r_err        <= 1'b0;
            r_word_valid <= 1'b0;
            r_word_data  <= '0;
        end else begin
            r_word_valid <= 1'b0;

            if (w_miss_hs) begin
                r_addr   <= align_line(bus.miss_addr);
                r_offset <= bus.miss_offset;
                r_we     <= bus.miss_we;
                r_wdata  <= bus.miss_wdata;
                r_wmask  <= bus.miss_wmask;
                r_cnt    <= '0;
                r_line   <= '0;
                r_err    <= 1'b0;
            end

            if (w_beat_hs) begin
                r_line[r_cnt] <= w_merged;
                // Hold the counter on the closing beat so it never wraps.
                if (!w_burst_end) begin
                    r_cnt <= r_cnt + OFF_W'(1);
                end
                if (w_burst_err) begin
                    r_err <= 1'b1;
                end
                // Critical word goes out raw, one cycle after its beat.
                if (!r_we && w_hit_offset) begin
                    r_word_valid <= 1'b1;
                    r_word_data  <= bus.rd_resp_data;
                end
                // r_offset > r_cnt here, so this never collides with the
                // beat write above.
                if (w_zero_merge) begin
                    r_line[r_offset] <= r_wdata & expand_mask(r_wmask);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Output data
    // ------------------------------------------------------------------
    assign bus.rd_req_addr = r_addr;
    assign bus.rd_req_len  = BURST_LEN;
    assign bus.word_valid  = r_word_valid;
    assign bus.word_data   = r_word_data;
    assign bus.line_data   = r_line;
    assign bus.line_addr   = r_addr;
    assign bus.err         = r_err;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_cache_refill_buffer.sv
module tb_cache_refill_buffer;
  import cache_pkg::*;

  localparam int CW = 640;
  typedef logic [CACHE_LINE_SIZE-1:0] line_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  state_t dbg_state;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cache_refill_buffer_if bus();

  cache_refill_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;

  line_t                 exp_line_q[$];
  logic [ADDR_WIDTH-1:0] exp_addr_q[$];
  logic                  exp_err_q[$];
  logic [DATA_WIDTH-1:0] exp_q[$];
  logic [ADDR_WIDTH-1:0] exp_req_addr = '0;

  logic [DATA_WIDTH-1:0] beat_mem[BEATS];
  int req_delay = 0;

  // observations recorded by the compare process
  int t0 = 0, t_req = -1, t_word = -1, t_line = -1, t_idle = -1;
  int n_word_pulses = 0;
  line_t last_line = '0;
  logic [DATA_WIDTH-1:0] last_word = '0;
  logic [ADDR_WIDTH-1:0] cap_req_addr = '0;
  logic prev_stall = 1'b0;
  logic [CW-1:0] prev_snap = '0;
  logic lv_prev = 1'b0, rq_prev = 1'b0, mr_prev = 1'b1;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [DATA_WIDTH-1:0] merge_model(input logic [DATA_WIDTH-1:0] o,
                                                        input logic [DATA_WIDTH-1:0] n,
                                                        input logic [MASK_W-1:0] m);
    logic [DATA_WIDTH-1:0] r;
    for (int b = 0; b < MASK_W; b++) r[8*b +: 8] = m[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
      lv_prev = 1'b0;
      rq_prev = 1'b0;
      mr_prev = 1'b1;
    end else begin
      if (bus.miss_valid && bus.miss_ready) t0 = cyc;
      if (bus.rd_req_valid) begin
        check("req_addr", CW'(bus.rd_req_addr), CW'(exp_req_addr));
        check("req_len", CW'(bus.rd_req_len), CW'(BEATS - 1));
        cap_req_addr = bus.rd_req_addr;
      end
      if (bus.word_valid) begin
        n_word_pulses++;
        t_word = cyc - t0;
        last_word = bus.word_data;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL word_unexpected: got pulse data %0h expected no pulse", bus.word_data);
        end else begin
          check("word_data", CW'(bus.word_data), CW'(exp_q.pop_front()));
        end
      end
      if (prev_stall)
        check("line_hold", CW'({bus.line_valid, bus.line_data, bus.line_addr}), prev_snap);
      if (bus.line_valid && bus.line_ready) begin
        last_line = bus.line_data;
        if (exp_line_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL line_unexpected: got line at %0h expected none", bus.line_addr);
        end else begin
          check("line_data", CW'(bus.line_data), CW'(exp_line_q.pop_front()));
          check("line_addr", CW'(bus.line_addr), CW'(exp_addr_q.pop_front()));
          check("line_err", CW'(bus.err), CW'(exp_err_q.pop_front()));
        end
      end
      if (bus.line_valid && !lv_prev) t_line = cyc - t0;
      if (bus.rd_req_valid && !rq_prev) t_req = cyc - t0;
      if (bus.miss_ready && !mr_prev) t_idle = cyc - t0;
      prev_stall = bus.line_valid && !bus.line_ready;
      prev_snap = CW'({bus.line_valid, bus.line_data, bus.line_addr});
      lv_prev = bus.line_valid;
      rq_prev = bus.rd_req_valid;
      mr_prev = bus.miss_ready;
    end
  end

  // ---------------- driver ----------------
  // gap_mode: 0 back-to-back, 1 alternate cycles, 2 random gaps.
  // last_at: beat index carrying rd_resp_last, -1 for none.
  // abort_after: number of beats after which reset is pulsed, -1 for none.
  task automatic do_miss(input logic [ADDR_WIDTH-1:0] addr, input int off, input logic we,
                         input logic [DATA_WIDTH-1:0] wdata, input logic [MASK_W-1:0] wmask,
                         input int gap_mode, input int last_at, input int stall,
                         input int abort_after);
    int nbeats, idx, guard;
    logic presented, tog, done;
    line_t l;
    logic [DATA_WIDTH-1:0] old_w;

    // reference model: what the line, word and err must be
    nbeats = (last_at >= 0 && last_at < BEATS) ? last_at + 1 : BEATS;
    l = '0;
    for (int i = 0; i < nbeats; i++) l[i*DATA_WIDTH +: DATA_WIDTH] = beat_mem[i];
    if (we) begin
      old_w = (off < nbeats) ? beat_mem[off] : '0;
      l[off*DATA_WIDTH +: DATA_WIDTH] = merge_model(old_w, wdata, wmask);
    end
    exp_req_addr = addr - (addr % (CACHE_LINE_SIZE / 8));
    if (abort_after < 0) begin
      exp_line_q.push_back(l);
      exp_addr_q.push_back(exp_req_addr);
      exp_err_q.push_back(last_at != BEATS - 1);
      if (!we && off < nbeats) exp_q.push_back(beat_mem[off]);
    end else if (!we && off < abort_after - 1) begin
      exp_q.push_back(beat_mem[off]);
    end

    // miss request
    @(posedge clk); #1;
    bus.miss_valid = 1'b1;
    bus.miss_addr = addr;
    bus.miss_offset = OFF_W'(off);
    bus.miss_we = we;
    bus.miss_wdata = wdata;
    bus.miss_wmask = wmask;
    guard = 0;
    while (!bus.miss_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    if (guard >= 50) fail_now("miss_timeout");
    @(posedge clk); #1;
    bus.miss_valid = 1'b0;
    check("err_clear", CW'(bus.err), CW'(1'b0));

    // burst request
    guard = 0;
    while (!bus.rd_req_valid && guard < 50) begin @(posedge clk); #1; guard++; end
    if (guard >= 50) fail_now("req_timeout");
    for (int d = 0; d < req_delay; d++) begin @(posedge clk); #1; end
    bus.rd_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.rd_req_ready = 1'b0;

    // beats
    idx = 0;
    tog = 1'b0;
    guard = 0;
    while (bus.rd_resp_ready && guard < 200 && idx < BEATS) begin
      if (abort_after >= 0 && idx == abort_after) break;
      case (gap_mode)
        0: presented = 1'b1;
        1: begin presented = tog; tog = !tog; end
        default: presented = 1'($urandom_range(0, 1));
      endcase
      bus.rd_resp_valid = presented;
      bus.rd_resp_data = presented ? beat_mem[idx] : $urandom;
      bus.rd_resp_last = presented && (idx == last_at);
      @(posedge clk); #1;
      if (presented) idx++;
      guard++;
    end
    bus.rd_resp_valid = 1'b0;
    bus.rd_resp_last = 1'b0;

    if (abort_after >= 0) begin
      reset = 1'b1;
      @(posedge clk); #1;
      check("post_reset_ctl", CW'({bus.miss_ready, bus.line_valid, bus.rd_resp_ready,
                                   bus.rd_req_valid, bus.word_valid, bus.err}), CW'(6'b100000));
      check("post_reset_line", CW'(bus.line_data), CW'(0));
      reset = 1'b0;
      return;
    end
    if (bus.rd_resp_ready) fail_now("burst_timeout");

    // line sink
    guard = 0;
    done = 1'b0;
    while (!done && guard < 100) begin
      if (bus.line_valid) begin
        if (stall > 0) begin bus.line_ready = 1'b0; stall--; end
        else begin bus.line_ready = 1'b1; done = 1'b1; end
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.line_ready = 1'b0;
    if (!done) fail_now("line_timeout");
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < BEATS; i++) beat_mem[i] = DATA_WIDTH'(32'h100 + i);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int pulses_before, r, last_at;

    bus.miss_valid = 1'b0; bus.miss_addr = '0; bus.miss_offset = '0; bus.miss_we = 1'b0;
    bus.miss_wdata = '0; bus.miss_wmask = '0; bus.rd_req_ready = 1'b0;
    bus.rd_resp_valid = 1'b0; bus.rd_resp_data = '0; bus.rd_resp_last = 1'b0;
    bus.line_ready = 1'b0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", CW'({bus.miss_ready, bus.rd_req_valid, bus.rd_resp_ready,
                            bus.word_valid, bus.line_valid, bus.err}), CW'(6'b100000));
    check("reset_data", CW'({bus.rd_req_addr, bus.word_data, bus.line_addr}), CW'(0));
    check("reset_line", CW'(bus.line_data), CW'(0));
    check("reset_state", CW'(dbg_state), CW'(IDLE));
    reset = 1'b0;

    // 1: load miss, nominal timing
    fill_pattern();
    req_delay = 0;
    do_miss(32'h8000_1234, 5, 1'b0, '0, '0, 0, 15, 0, -1);
    @(negedge clk); #1;
    check("s1_req_addr", CW'(cap_req_addr), CW'(32'h8000_1200));
    check("s1_word_data", CW'(last_word), CW'(32'h105));
    check("s1_t_req", CW'(t_req), CW'(1));
    check("s1_t_word", CW'(t_word), CW'(8));
    check("s1_t_line", CW'(t_line), CW'(18));
    check("s1_t_idle", CW'(t_idle), CW'(19));
    check("s1_word0", CW'(last_line[31:0]), CW'(32'h100));
    check("s1_word15", CW'(last_line[511:480]), CW'(32'h10F));
    check("s1_err", CW'(bus.err), CW'(1'b0));

    // 2: store miss merge at offset 0
    fill_pattern();
    beat_mem[0] = 32'h1122_3344;
    pulses_before = n_word_pulses;
    do_miss(32'h0000_4040, 0, 1'b1, 32'hAABB_CCDD, 4'b0101, 0, 15, 0, -1);
    check("s2_word0", CW'(last_line[31:0]), CW'(32'h11BB_33DD));
    check("s2_word1", CW'(last_line[63:32]), CW'(32'h101));
    check("s2_no_pulse", CW'(n_word_pulses - pulses_before), CW'(0));

    // 3: alternating beat gaps, line write stalled 5 cycles
    fill_pattern();
    do_miss(32'h8000_1234, 5, 1'b0, '0, '0, 1, 15, 5, -1);
    check("s3_word_data", CW'(last_word), CW'(32'h105));

    // 4: early last on beat 9
    fill_pattern();
    do_miss(32'h1234_5678, 3, 1'b0, '0, '0, 0, 9, 0, -1);
    check("s4_err", CW'(bus.err), CW'(1'b1));
    check("s4_tail_zero", CW'(last_line[511:320]), CW'(0));

    // 5: reset during RECV after beat 7, then a clean refill
    fill_pattern();
    do_miss(32'h0000_0F00, 3, 1'b0, '0, '0, 0, 15, 0, 8);
    for (int i = 0; i < BEATS; i++) beat_mem[i] = $urandom;
    do_miss(32'h0BAD_F00D, 12, 1'b0, '0, '0, 0, 15, 0, -1);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < BEATS; i++) beat_mem[i] = $urandom;
      r = $urandom_range(0, 9);
      if (r < 7) last_at = 15;
      else if (r < 9) last_at = $urandom_range(0, 14);
      else last_at = -1;
      req_delay = $urandom_range(0, 2);
      do_miss($urandom, $urandom_range(0, BEATS - 1), 1'($urandom_range(0, 1)), $urandom,
              MASK_W'($urandom_range(0, 15)), $urandom_range(0, 2), last_at,
              $urandom_range(0, 3), -1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("left_lines", CW'(exp_line_q.size()), CW'(0));
    check("left_words", CW'(exp_q.size()), CW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
